// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with a one-entry skid buffer, flush-to-NOP,
// sticky halt and saturating stall/flush counters.
module pipe_stage_reg #(
  parameter int                 INSTR_W   = 16,
  parameter int                 PC_W      = 16,
  parameter logic [INSTR_W-1:0] NOP       = 16'h0800,
  parameter bit                 FLUSH_PRI = 1'b0,
  parameter int                 CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic               in_halt,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic               out_halt,
  output logic               halted,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  logic               main_valid_q, main_valid_d;
  logic [INSTR_W-1:0] main_instr_q, main_instr_d;
  logic [PC_W-1:0]    main_pc_q,    main_pc_d;
  logic               main_halt_q,  main_halt_d;
  logic               skid_valid_q, skid_valid_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]    skid_pc_q,    skid_pc_d;
  logic               skid_halt_q,  skid_halt_d;
  logic               halted_q,     halted_d;
  logic               in_ready_q,   in_ready_d;
  logic [CNT_W-1:0]   stall_cnt_q,  stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q,  flush_cnt_d;

  logic               up_xfer, dn_xfer, stalled, halt_dn;
  logic [1:0]         n_drop;
  logic [CNT_W:0]     flush_sum;

  always_comb begin
    up_xfer = in_valid && in_ready_q;
    dn_xfer = main_valid_q && out_ready;
    stalled = main_valid_q && !out_ready;
    halt_dn = dn_xfer && main_halt_q;

    main_valid_d = main_valid_q;
    main_instr_d = main_instr_q;
    main_pc_d    = main_pc_q;
    main_halt_d  = main_halt_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_halt_d  = skid_halt_q;
    n_drop       = 2'd0;

    if (flush) begin
      skid_valid_d = 1'b0;
      if (FLUSH_PRI || !stalled) begin
        main_valid_d = 1'b0;
        main_instr_d = NOP;
        main_pc_d    = '0;
        main_halt_d  = 1'b0;
      end
      // at most two: a full skid forces in_ready low, so skid and input never both drop
      n_drop = {1'b0, up_xfer} + {1'b0, skid_valid_q} + {1'b0, FLUSH_PRI && stalled};
    end else if (halt_dn) begin
      // nothing behind a consumed halt may reach the output
      main_valid_d = 1'b0;
      main_instr_d = NOP;
      main_pc_d    = '0;
      main_halt_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || dn_xfer) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_instr_d = skid_instr_q;
        main_pc_d    = skid_pc_q;
        main_halt_d  = skid_halt_q;
        skid_valid_d = 1'b0;
      end else if (up_xfer) begin
        main_valid_d = 1'b1;
        main_instr_d = in_instr;
        main_pc_d    = in_pc;
        main_halt_d  = in_halt;
      end else begin
        main_valid_d = 1'b0;
        main_instr_d = NOP;
        main_pc_d    = '0;
        main_halt_d  = 1'b0;
      end
    end else if (up_xfer) begin
      skid_valid_d = 1'b1;
      skid_instr_d = in_instr;
      skid_pc_d    = in_pc;
      skid_halt_d  = in_halt;
    end

    halted_d   = halted_q || halt_dn;
    in_ready_d = !skid_valid_d && !halted_d;

    stall_cnt_d = stall_cnt_q;
    if (stalled && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);

    flush_sum   = {1'b0, flush_cnt_q} + (CNT_W+1)'(n_drop);
    flush_cnt_d = flush_sum[CNT_W] ? '1 : flush_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_instr_q <= NOP;
      main_pc_q    <= '0;
      main_halt_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      skid_halt_q  <= 1'b0;
      halted_q     <= 1'b0;
      in_ready_q   <= 1'b1;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_instr_q <= main_instr_d;
      main_pc_q    <= main_pc_d;
      main_halt_q  <= main_halt_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_halt_q  <= skid_halt_d;
      halted_q     <= halted_d;
      in_ready_q   <= in_ready_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign out_instr = main_instr_q;
  assign out_pc    = main_pc_q;
  assign out_halt  = main_halt_q;
  assign halted    = halted_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
